// File: rtl/banco_registrador_param_if.sv
// banco_registrador_param_if: decode/writeback bus of the register file
interface banco_registrador_param_if #(
  parameter int LARGURA = 32,
  parameter int END_BITS = 6
);
  logic [END_BITS-1:0] end_escrita;
  logic [END_BITS-1:0] end_leitura1;
  logic [END_BITS-1:0] end_leitura2;
  logic [LARGURA-1:0] dados_escrita;
  logic EscreveReg;
  logic [LARGURA-1:0] leitura1;
  logic [LARGURA-1:0] leitura2;
  logic pronto;
  modport master (
    output end_escrita, end_leitura1, end_leitura2, dados_escrita, EscreveReg,
    input leitura1, leitura2, pronto
  );
  modport slave (
    input end_escrita, end_leitura1, end_leitura2, dados_escrita, EscreveReg,
    output leitura1, leitura2, pronto
  );
endinterface

// File: rtl/banco_registrador_param.sv
// banco_registrador_param: register file with post-reset clear engine, forwarding and optional hardwired r0
module banco_registrador_param #(
  parameter int LARGURA = 32,
  parameter int NUM_REG = 64,
  parameter int END_BITS = 6,
  parameter int R1_INIT = 13249,
  parameter int ZERO_FIXO = 1
) (
  input logic clock,
  input logic reset_n,
  banco_registrador_param_if.slave bus
);
  typedef enum logic {LIMPANDO, PRONTO} estado_t;
  localparam logic [LARGURA-1:0] R1_VAL = LARGURA'(R1_INIT);
  localparam logic [END_BITS-1:0] ULTIMO = END_BITS'(NUM_REG - 1);
  localparam logic [END_BITS-1:0] UM = END_BITS'(1);
  estado_t estado_q, estado_d;
  logic [END_BITS-1:0] cont_q, cont_d;
  logic pronto_q, pronto_d;
  logic [LARGURA-1:0] regs [NUM_REG];
  logic limpando, fim, escreve;
  logic [END_BITS-1:0] end_w;
  logic [LARGURA-1:0] dado_w;
  always_comb begin
    limpando = estado_q == LIMPANDO;
    fim = limpando && cont_q == ULTIMO;
    estado_d = fim ? PRONTO : estado_q;
    cont_d = limpando ? cont_q + UM : cont_q;
    pronto_d = pronto_q | fim;
    escreve = reset_n && (limpando ||
              (bus.EscreveReg && !(ZERO_FIXO != 0 && bus.end_escrita == '0)));
    end_w = limpando ? cont_q : bus.end_escrita;
    dado_w = limpando ? (cont_q == UM ? R1_VAL : '0) : bus.dados_escrita;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q <= LIMPANDO;
      cont_q <= '0;
      pronto_q <= 1'b0;
    end else begin
      estado_q <= estado_d;
      cont_q <= cont_d;
      pronto_q <= pronto_d;
    end
  end
  // The array has no reset; the clear engine owns it until PRONTO.
  always_ff @(posedge clock) begin
    if (escreve) regs[end_w] <= dado_w;
  end
  assign bus.leitura1 = limpando || (ZERO_FIXO != 0 && bus.end_leitura1 == '0) ? '0 :
                        (bus.EscreveReg && bus.end_escrita == bus.end_leitura1) ? bus.dados_escrita :
                        regs[bus.end_leitura1];
  assign bus.leitura2 = limpando || (ZERO_FIXO != 0 && bus.end_leitura2 == '0) ? '0 :
                        (bus.EscreveReg && bus.end_escrita == bus.end_leitura2) ? bus.dados_escrita :
                        regs[bus.end_leitura2];
  assign bus.pronto = pronto_q;
endmodule
